// File: rtl/game_state_ctrl_pkg.sv
// Shared types and constants for the pacman game sequencer.
package pacman_pkg;

   localparam int TIMER_W = 10;

   localparam int START_LIVES_DEF  = 3;
   localparam int READY_FRAMES_DEF = 60;
   localparam int POWER_FRAMES_DEF = 360;
   localparam int WARN_FRAMES_DEF  = 120;
   localparam int DEATH_FRAMES_DEF = 120;

   typedef enum logic [2:0] {
      ST_READY   = 3'd0,
      ST_PLAY    = 3'd1,
      ST_POWER   = 3'd2,
      ST_DYING   = 3'd3,
      ST_RESPAWN = 3'd4,
      ST_WIN     = 3'd5,
      ST_OVER    = 3'd6
   } game_state_t;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Game event inputs and movement-control outputs of the sequencer.
interface game_state_ctrl_if;
   import pacman_pkg::*;

   logic        collision;
   logic        power_pellet;
   logic        level_clear;
   logic        death;
   logic        isDefeated;
   logic        reversal;
   logic        power_warn;
   logic        ghost_eaten;
   logic [1:0]  lives;
   game_state_t game_state;

   // Collision/dot logic side: raises events, observes controls.
   modport master (
      output collision, power_pellet, level_clear,
      input  death, isDefeated, reversal, power_warn, ghost_eaten, lives, game_state
   );

   // Sequencer side.
   modport slave (
      input  collision, power_pellet, level_clear,
      output death, isDefeated, reversal, power_warn, ghost_eaten, lives, game_state
   );

endinterface

// File: rtl/game_state_ctrl_frame_timer.sv
// Loadable frame down counter; saturates at zero, expired flags zero.
module frame_timer
   import pacman_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic [TIMER_W-1:0] count,
   output logic               expired
);

   // Count down each frame; a load takes priority over counting.
   always_ff @(posedge frame_clk or posedge Reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset)
         count <= RESET_VAL;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 1'b1;
   end

   assign expired = (count == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Frame-rate game sequencer: ready countdown, power window, death hold,
// respawn pulse, lives, and terminal win/over states.
module game_state_ctrl
   import pacman_pkg::*;
#(
   parameter int START_LIVES  = START_LIVES_DEF,
   parameter int READY_FRAMES = READY_FRAMES_DEF,
   parameter int POWER_FRAMES = POWER_FRAMES_DEF,
   parameter int WARN_FRAMES  = WARN_FRAMES_DEF,
   parameter int DEATH_FRAMES = DEATH_FRAMES_DEF
) (
   input logic               frame_clk,
   input logic               Reset,
   game_state_ctrl_if.slave  gs
);

   // Timers load N-1 so the timed state lasts exactly N frames.
   localparam logic [TIMER_W-1:0] READY_LOAD = TIMER_W'(READY_FRAMES - 1);
   localparam logic [TIMER_W-1:0] POWER_LOAD = TIMER_W'(POWER_FRAMES - 1);
   localparam logic [TIMER_W-1:0] DEATH_LOAD = TIMER_W'(DEATH_FRAMES - 1);
   localparam logic [TIMER_W-1:0] WARN_LIM   = TIMER_W'(WARN_FRAMES);
   localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);

   game_state_t        state_q, state_d;
   logic [1:0]         lives_q;
   logic               lives_dec;
   logic               ghost_eaten_q, ghost_eaten_d;
   logic               load;
   logic [TIMER_W-1:0] load_val;
   logic [TIMER_W-1:0] count;
   logic               expired;

   frame_timer #(.RESET_VAL(READY_LOAD)) u_timer (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (load),
      .load_val  (load_val),
      .count     (count),
      .expired   (expired)
   );

   // State, lives and ghost-eaten pulse registers.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_READY;
         lives_q       <= LIVES_INIT;
         ghost_eaten_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ghost_eaten_q <= ghost_eaten_d;
         if (lives_dec && lives_q != 2'd0)
            lives_q <= lives_q - 2'd1;
      end
   end

   // Next-state, timer reload and event priority per state.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d       = state_q;
      load          = 1'b0;
      load_val      = READY_LOAD;
      lives_dec     = 1'b0;
      ghost_eaten_d = 1'b0;
      case (state_q)
         ST_READY: begin
            if (expired) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (gs.level_clear) begin
               state_d = ST_WIN;
            end else if (gs.collision) begin
               state_d  = ST_DYING;
               load     = 1'b1;
               load_val = DEATH_LOAD;
            end else if (gs.power_pellet) begin
               state_d  = ST_POWER;
               load     = 1'b1;
               load_val = POWER_LOAD;
            end
         end
         ST_POWER: begin
            if (gs.level_clear) begin
               state_d = ST_WIN;
            end else if (gs.collision) begin
               ghost_eaten_d = 1'b1;
            end else if (gs.power_pellet) begin
               load     = 1'b1;
               load_val = POWER_LOAD;
            end else if (expired) begin
               state_d = ST_PLAY;
            end
         end
         ST_DYING: begin
            if (expired) begin
               lives_dec = 1'b1;
               state_d   = (lives_q <= 2'd1) ? ST_OVER : ST_RESPAWN;
            end
         end
         ST_RESPAWN: begin
            state_d  = ST_READY;
            load     = 1'b1;
            load_val = READY_LOAD;
         end
         default: ; // WIN and OVER hold until reset
      endcase
   end

   // Moore output decode.
   always_comb begin
      gs.death      = (state_q == ST_READY) || (state_q == ST_DYING) ||
                      (state_q == ST_WIN)   || (state_q == ST_OVER);
      gs.reversal   = (state_q == ST_POWER);
      gs.isDefeated = (state_q == ST_RESPAWN);
      gs.power_warn = (state_q == ST_POWER) && (count < WARN_LIM);
   end

   assign gs.ghost_eaten = ghost_eaten_q;
   assign gs.lives       = lives_q;
   assign gs.game_state  = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed, table-driven bench for game_state_ctrl.
module tb_game_state_ctrl;
   import pacman_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   game_state_ctrl_if gs();

   game_state_ctrl #(
      .START_LIVES  (3),
      .READY_FRAMES (4),
      .POWER_FRAMES (8),
      .WARN_FRAMES  (3),
      .DEATH_FRAMES (5)
   ) dut (
      .frame_clk (clk),
      .Reset     (rst),
      .gs        (gs)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       c, p, l;
      logic [2:0] st;
      logic       death, rev, warn, isdef, ge;
      logic [1:0] lives;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic c, p, l, input logic [2:0] st,
                      input logic death, rev, warn, isdef, ge,
                      input logic [1:0] lives, input int n);
      vec_t v;
      v.c = c; v.p = p; v.l = l; v.st = st;
      v.death = death; v.rev = rev; v.warn = warn; v.isdef = isdef; v.ge = ge;
      v.lives = lives;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] st,
                            input logic death, rev, warn, isdef, ge,
                            input logic [1:0] lives);
      check({tag, " state"},       8'(gs.game_state), 8'(st));
      check({tag, " death"},       8'(gs.death),      8'(death));
      check({tag, " reversal"},    8'(gs.reversal),   8'(rev));
      check({tag, " power_warn"},  8'(gs.power_warn), 8'(warn));
      check({tag, " isDefeated"},  8'(gs.isDefeated), 8'(isdef));
      check({tag, " ghost_eaten"}, 8'(gs.ghost_eaten),8'(ge));
      check({tag, " lives"},       8'(gs.lives),      8'(lives));
   endtask

   // Drive inputs, take one frame edge, settle past the edge.
   task automatic step(input logic c, p, l);
      gs.collision    = c;
      gs.power_pellet = p;
      gs.level_clear  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      gs.collision    = 1'b0;
      gs.power_pellet = 1'b0;
      gs.level_clear  = 1'b0;

      // Ready countdown, pellet window, pellet at timer 0, ghost eaten.
      add(0,0,0, ST_READY,  1,0,0,0,0, 3, 3);
      add(0,0,0, ST_PLAY,   0,0,0,0,0, 3, 1);
      add(0,1,0, ST_POWER,  0,1,0,0,0, 3, 1);
      add(0,0,0, ST_POWER,  0,1,0,0,0, 3, 4);
      add(0,0,0, ST_POWER,  0,1,1,0,0, 3, 3);
      add(0,0,0, ST_PLAY,   0,0,0,0,0, 3, 1);
      add(0,1,0, ST_POWER,  0,1,0,0,0, 3, 1);
      add(0,0,0, ST_POWER,  0,1,0,0,0, 3, 4);
      add(0,0,0, ST_POWER,  0,1,1,0,0, 3, 3);
      add(0,1,0, ST_POWER,  0,1,0,0,0, 3, 1);
      add(1,0,0, ST_POWER,  0,1,0,0,1, 3, 1);
      add(0,0,0, ST_POWER,  0,1,0,0,0, 3, 3);
      add(0,0,0, ST_POWER,  0,1,1,0,0, 3, 3);
      add(0,0,0, ST_PLAY,   0,0,0,0,0, 3, 1);
      // First death; inputs during DYING/RESPAWN/READY are ignored.
      add(1,0,0, ST_DYING,  1,0,0,0,0, 3, 2);
      add(1,1,0, ST_DYING,  1,0,0,0,0, 3, 1);
      add(0,0,0, ST_DYING,  1,0,0,0,0, 3, 2);
      add(0,0,0, ST_RESPAWN,0,0,0,1,0, 2, 1);
      add(1,0,0, ST_READY,  1,0,0,0,0, 2, 1);
      add(0,0,1, ST_READY,  1,0,0,0,0, 2, 1);
      add(0,0,0, ST_READY,  1,0,0,0,0, 2, 2);
      add(0,0,0, ST_PLAY,   0,0,0,0,0, 2, 1);
      // Second death.
      add(1,0,0, ST_DYING,  1,0,0,0,0, 2, 1);
      add(0,0,0, ST_DYING,  1,0,0,0,0, 2, 4);
      add(0,0,0, ST_RESPAWN,0,0,0,1,0, 1, 1);
      add(0,0,0, ST_READY,  1,0,0,0,0, 1, 4);
      add(0,0,0, ST_PLAY,   0,0,0,0,0, 1, 1);
      // Third death ends the game; OVER ignores everything.
      add(1,0,0, ST_DYING,  1,0,0,0,0, 1, 1);
      add(0,0,0, ST_DYING,  1,0,0,0,0, 1, 4);
      add(0,0,0, ST_OVER,   1,0,0,0,0, 0, 1);
      add(1,0,0, ST_OVER,   1,0,0,0,0, 0, 1);
      add(0,1,0, ST_OVER,   1,0,0,0,0, 0, 1);
      add(0,0,1, ST_OVER,   1,0,0,0,0, 0, 1);

      do_reset();
      check_out("reset", ST_READY, 1,0,0,0,0, 3);

      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].p, vecs[i].l);
         check_out($sformatf("v%0d", i), vecs[i].st, vecs[i].death, vecs[i].rev,
                   vecs[i].warn, vecs[i].isdef, vecs[i].ge, vecs[i].lives);
      end

      // Reset out of OVER, then simultaneous inputs in PLAY: WIN wins.
      do_reset();
      check_out("reset_from_over", ST_READY, 1,0,0,0,0, 3);
      repeat (4) step(0,0,0);
      check_out("play_again", ST_PLAY, 0,0,0,0,0, 3);
      step(1,1,1);
      check_out("all_inputs", ST_WIN, 1,0,0,0,0, 3);
      step(1,1,0);
      check_out("win_hold", ST_WIN, 1,0,0,0,0, 3);

      // Level clear in POWER goes to WIN with no ghost pulse.
      do_reset();
      repeat (4) step(0,0,0);
      step(0,1,0);
      step(1,0,1);
      check_out("power_clear", ST_WIN, 1,0,0,0,0, 3);

      // Asynchronous reset in the middle of the second DYING.
      do_reset();
      repeat (4) step(0,0,0);
      step(1,0,0);
      repeat (5) step(0,0,0);
      check_out("respawn2", ST_RESPAWN, 0,0,0,1,0, 2);
      repeat (5) step(0,0,0);
      check_out("play2", ST_PLAY, 0,0,0,0,0, 2);
      step(1,0,0);
      step(0,0,0);
      check_out("mid_dying", ST_DYING, 1,0,0,0,0, 2);
      #2;
      rst = 1'b1;
      #1;
      check_out("async_reset", ST_READY, 1,0,0,0,0, 3);
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Frame-rate game sequencer that drives the pacman movement block's `death`, `isDefeated` and `reversal` controls. It owns the ready countdown, power-pellet (reversal) window, death animation hold, respawn pulse, life count, level-clear and game-over states. It sits between the collision/dot logic and the pacman and ghost movers, and runs on the same `frame_clk`.

## Interface
- `START_LIVES`, default 3: lives loaded at reset (1..3).
- `READY_FRAMES`, default 60: frames the player is frozen before play.
- `POWER_FRAMES`, default 360: length of the reversal window.
- `WARN_FRAMES`, default 120: final frames of the power window that assert `power_warn`; must be less than `POWER_FRAMES`.
- `DEATH_FRAMES`, default 120: length of the death hold.

Ports:
- `frame_clk`, in, 1: frame clock; all state changes on its rising edge.
- `Reset`, in, 1: asynchronous, active-high.
- `collision`, in, 1: pacman overlaps a ghost this frame.
- `power_pellet`, in, 1: pacman ate a power pellet this frame (single-frame pulse).
- `level_clear`, in, 1: dot count reached zero.
- `death`, out, 1: freeze pacman motion.
- `isDefeated`, out, 1: one-frame respawn pulse that returns pacman to its start position.
- `reversal`, out, 1: power mode active; ghosts flee.
- `power_warn`, out, 1: power mode is in its last `WARN_FRAMES` frames.
- `ghost_eaten`, out, 1: registered one-frame pulse when a ghost is eaten.
- `lives`, out, 2: remaining lives.
- `game_state`, out, 3: current state (encoding from the package).

## Operation
States: READY=0, PLAY=1, POWER=2, DYING=3, RESPAWN=4, WIN=5, OVER=6.

Timer: 10-bit down counter.
- On entry to a timed state it loads N-1.
- The state exits on the frame the counter reads 0, so the state lasts exactly N frames.

Transitions:
- READY: on timer expiry, go to PLAY.
- PLAY: evaluate inputs in priority order.
  1. `level_clear`: go to WIN.
  2. `collision`: go to DYING and load `DEATH_FRAMES`.
  3. `power_pellet`: go to POWER and load `POWER_FRAMES`.
- POWER: evaluate inputs in priority order.
  1. `level_clear`: go to WIN.
  2. `collision`: pulse `ghost_eaten` and stay in POWER; the timer keeps counting.
  3. `power_pellet`: reload `POWER_FRAMES`.
  4. Timer expiry: go to PLAY.
  - If `power_pellet` arrives on the expiry frame, the reload wins and the state stays POWER.
- DYING: on expiry, decrement `lives`.
  - If `lives` was 1, it becomes 0 and the state goes to OVER.
  - Otherwise go to RESPAWN.
- RESPAWN: lasts one frame, then go to READY and load `READY_FRAMES`.
- WIN and OVER: terminal; only `Reset` leaves them. All inputs are ignored.

Moore output decode:
- `death` = 1 in READY, DYING, WIN and OVER.
- `reversal` = 1 in POWER only.
- `isDefeated` = 1 in RESPAWN only; `reversal` is always 0 there, so pacman re-centres.
- `power_warn` = 1 when in POWER and timer < `WARN_FRAMES`.

Other rules:
- Inputs outside the states that consume them are ignored. For example, `collision` during DYING, READY or RESPAWN has no effect.
- `lives` never underflows and never increments.

## Timing
- Reset values:
  - `game_state` = READY, timer = `READY_FRAMES`-1, `lives` = `START_LIVES`.
  - `death` = 1; `isDefeated`, `reversal`, `power_warn` and `ghost_eaten` = 0.
- Reset asserted mid-operation (any state) returns to the reset values immediately, without waiting for a clock edge.
- Input sampled at edge k: the new state and its decoded outputs are valid after edge k, i.e. during frame k+1.
  - `ghost_eaten` is high for exactly the frame after the edge that sampled the collision.
- A sustained `collision` in POWER pulses `ghost_eaten` every frame. Upstream must de-duplicate per ghost.
- Timer reload and state change happen on the same edge. There are no idle frames between states except RESPAWN, which is exactly one frame.

## Structure
- `pacman_pkg` holds:
  - the `game_state_t` enum (3-bit, encoding above);
  - the default frame-count constants;
  - the 10-bit `TIMER_W` constant.
- Sub-module `frame_timer`:
  - loadable 10-bit down counter;
  - ports: `frame_clk`, `Reset`, `load`, `load_val`, `count`;
  - `expired` output = (count == 0).
- The FSM, priority logic and lives register stay in `game_state_ctrl`.

## Test plan
Run with `READY_FRAMES`=4, `POWER_FRAMES`=8, `WARN_FRAMES`=3, `DEATH_FRAMES`=5 and `START_LIVES`=3.
- **Reset, no stimulus:** `death`=1 for frames 0-3; PLAY at frame 4 with `death`=0 and `lives`=3.
- **Pellet with no refresh:**
  - `power_pellet` in PLAY: `reversal`=1 for exactly 8 frames.
  - `power_warn`=1 on the last 3 of those frames, then back to PLAY.
  - A second pellet at timer=0 extends POWER by 8 frames.
- **Collision in POWER:** a one-frame `collision` gives `ghost_eaten`=1 for one frame; state stays POWER and the timer is unaffected.
- **Collision in PLAY:**
  - DYING with `death`=1 for 5 frames.
  - Then `lives`=2 and RESPAWN with `isDefeated`=1 for one frame and `reversal`=0.
  - Then READY for 4 frames.
- **Three deaths:** after the third DYING, `lives`=0 and the state is OVER with `death`=1. Further `collision`, `power_pellet` and `level_clear` inputs cause no change.
- **Simultaneous inputs and mid-operation reset:**
  - `level_clear`+`collision`+`power_pellet` in the same PLAY frame: WIN wins.
  - `Reset` asserted mid-DYING: immediate READY, `lives`=3, `death`=1.
